// File: rtl/hdmi_audio_sched.sv
// Audio sample scheduler for the HDMI encoder: a fractional phase accumulator turns
// the pixel clock into a 48 kHz clk_audio, and two stereo sources are attenuated, mixed and saturated.
module hdmi_audio_sched #(
  parameter int CLK_HZ    = 40000000,
  parameter int SAMPLE_HZ = 48000,
  parameter int ACC_W     = 27
) (
  input  logic               clk_pixel,
  input  logic               resetn,
  input  logic               src0_valid,
  output logic               src0_ready,
  input  logic signed [15:0] src0_l,
  input  logic signed [15:0] src0_r,
  input  logic               src1_valid,
  output logic               src1_ready,
  input  logic signed [15:0] src1_l,
  input  logic signed [15:0] src1_r,
  input  logic [1:0]         cfg_en,
  input  logic [1:0]         cfg_shift0,
  input  logic [1:0]         cfg_shift1,
  input  logic               clr_stats,
  output logic               clk_audio,
  output logic               sample_tick,
  output logic signed [15:0] audio0,
  output logic signed [15:0] audio1,
  output logic [7:0]         underrun0,
  output logic [7:0]         underrun1
);

  localparam logic [ACC_W-1:0] INC   = ACC_W'(2 * SAMPLE_HZ);
  localparam logic [ACC_W-1:0] LIMIT = ACC_W'(CLK_HZ);

  typedef enum logic [1:0] {IDLE, SNAP, SUM, SAT} state_t;

  function automatic logic signed [15:0] attn(input logic signed [15:0] x,
                                              input logic [1:0]         sh);
    return x >>> sh;
  endfunction

  // A 17-bit sum overflows 16 bits exactly when its top two bits disagree.
  function automatic logic signed [15:0] sat16(input logic signed [16:0] s);
    if (s[16] != s[15]) return s[16] ? 16'sh8000 : 16'sh7FFF;
    return s[15:0];
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] u);
    return (u == 8'hFF) ? u : u + 8'd1;
  endfunction

  // Control state (reset)
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic               clk_audio_q, clk_audio_d;
  logic               sample_tick_q, sample_tick_d;
  state_t             state_q, state_d;
  logic [1:0]         full_q, full_d;
  logic signed [15:0] last_l_q [2];
  logic signed [15:0] last_l_d [2];
  logic signed [15:0] last_r_q [2];
  logic signed [15:0] last_r_d [2];
  logic [7:0]         underrun_q [2];
  logic [7:0]         underrun_d [2];
  logic signed [15:0] audio0_q, audio0_d;
  logic signed [15:0] audio1_q, audio1_d;

  // Datapath state (no reset)
  logic signed [15:0] hold_l_q [2];
  logic signed [15:0] hold_l_d [2];
  logic signed [15:0] hold_r_q [2];
  logic signed [15:0] hold_r_d [2];
  logic signed [15:0] snap_l_q [2];
  logic signed [15:0] snap_l_d [2];
  logic signed [15:0] snap_r_q [2];
  logic signed [15:0] snap_r_d [2];
  logic signed [16:0] sum_l_q, sum_l_d;
  logic signed [16:0] sum_r_q, sum_r_d;

  // Per-source views of the flat port list
  logic [1:0]         in_vld;
  logic [1:0]         in_rdy;
  logic signed [15:0] in_l [2];
  logic signed [15:0] in_r [2];
  logic [1:0]         shift [2];

  logic [ACC_W-1:0]   acc_sum;
  logic               toggle;
  logic signed [15:0] pick_l [2];
  logic signed [15:0] pick_r [2];

  assign in_vld   = {src1_valid, src0_valid};
  assign in_rdy   = ~full_q & {2{resetn}};
  assign in_l[0]  = src0_l;
  assign in_l[1]  = src1_l;
  assign in_r[0]  = src0_r;
  assign in_r[1]  = src1_r;
  assign shift[0] = cfg_shift0;
  assign shift[1] = cfg_shift1;

  always_comb begin
    acc_sum       = acc_q + INC;
    toggle        = (acc_sum >= LIMIT);
    acc_d         = toggle ? (acc_sum - LIMIT) : acc_sum;
    clk_audio_d   = clk_audio_q ^ toggle;
    sample_tick_d = toggle & ~clk_audio_q;

    state_d    = state_q;
    full_d     = full_q;
    last_l_d   = last_l_q;
    last_r_d   = last_r_q;
    underrun_d = underrun_q;
    audio0_d   = audio0_q;
    audio1_d   = audio1_q;
    hold_l_d   = hold_l_q;
    hold_r_d   = hold_r_q;
    snap_l_d   = snap_l_q;
    snap_r_d   = snap_r_q;
    sum_l_d    = sum_l_q;
    sum_r_d    = sum_r_q;
    pick_l     = '{default: '0};
    pick_r     = '{default: '0};

    case (state_q)
      IDLE: begin
        if (toggle && clk_audio_q) state_d = SNAP;
      end
      SNAP: begin
        state_d = SUM;
        for (int n = 0; n < 2; n++) begin
          if (cfg_en[n]) begin
            if (full_q[n]) begin
              pick_l[n]   = hold_l_q[n];
              pick_r[n]   = hold_r_q[n];
              last_l_d[n] = hold_l_q[n];
              last_r_d[n] = hold_r_q[n];
              full_d[n]   = 1'b0;
            end else begin
              // Starved source repeats its previous sample and is counted.
              pick_l[n]     = last_l_q[n];
              pick_r[n]     = last_r_q[n];
              underrun_d[n] = sat_inc8(underrun_q[n]);
            end
          end else begin
            full_d[n] = 1'b0;
          end
          snap_l_d[n] = attn(pick_l[n], shift[n]);
          snap_r_d[n] = attn(pick_r[n], shift[n]);
        end
      end
      SUM: begin
        state_d = SAT;
        sum_l_d = $signed({snap_l_q[0][15], snap_l_q[0]}) + $signed({snap_l_q[1][15], snap_l_q[1]});
        sum_r_d = $signed({snap_r_q[0][15], snap_r_q[0]}) + $signed({snap_r_q[1][15], snap_r_q[1]});
      end
      SAT: begin
        state_d  = IDLE;
        audio0_d = sat16(sum_l_q);
        audio1_d = sat16(sum_r_q);
      end
      default: state_d = IDLE;
    endcase

    // A load on the snapshot cycle lands after the snapshot decision, so it is kept for the next period.
    for (int n = 0; n < 2; n++) begin
      if (in_vld[n] && in_rdy[n]) begin
        hold_l_d[n] = in_l[n];
        hold_r_d[n] = in_r[n];
        full_d[n]   = 1'b1;
      end
    end

    if (clr_stats) underrun_d = '{default: '0};
  end

  always_ff @(posedge clk_pixel) begin
    if (!resetn) begin
      acc_q         <= '0;
      clk_audio_q   <= 1'b0;
      sample_tick_q <= 1'b0;
      state_q       <= IDLE;
      full_q        <= '0;
      last_l_q      <= '{default: '0};
      last_r_q      <= '{default: '0};
      underrun_q    <= '{default: '0};
      audio0_q      <= '0;
      audio1_q      <= '0;
    end else begin
      acc_q         <= acc_d;
      clk_audio_q   <= clk_audio_d;
      sample_tick_q <= sample_tick_d;
      state_q       <= state_d;
      full_q        <= full_d;
      last_l_q      <= last_l_d;
      last_r_q      <= last_r_d;
      underrun_q    <= underrun_d;
      audio0_q      <= audio0_d;
      audio1_q      <= audio1_d;
    end
  end

  always_ff @(posedge clk_pixel) begin
    hold_l_q <= hold_l_d;
    hold_r_q <= hold_r_d;
    snap_l_q <= snap_l_d;
    snap_r_q <= snap_r_d;
    sum_l_q  <= sum_l_d;
    sum_r_q  <= sum_r_d;
  end

  assign src0_ready  = in_rdy[0];
  assign src1_ready  = in_rdy[1];
  assign clk_audio   = clk_audio_q;
  assign sample_tick = sample_tick_q;
  assign audio0      = audio0_q;
  assign audio1      = audio1_q;
  assign underrun0   = underrun_q[0];
  assign underrun1   = underrun_q[1];

endmodule

// File: tb/tb_hdmi_audio_sched.sv
// Directed bench for hdmi_audio_sched: a 40 MHz instance for timing and mixing, and a
// fast-rate instance (10-cycle half periods) to reach underrun saturation quickly.
module tb_hdmi_audio_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // Main instance
  logic               resetn = 1'b0;
  logic               src0_valid = 1'b0, src1_valid = 1'b0;
  logic               src0_ready, src1_ready;
  logic signed [15:0] src0_l = '0, src0_r = '0, src1_l = '0, src1_r = '0;
  logic [1:0]         cfg_en = 2'b00, cfg_shift0 = 2'd0, cfg_shift1 = 2'd0;
  logic               clr_stats = 1'b0;
  logic               clk_audio, sample_tick;
  logic signed [15:0] audio0, audio1;
  logic [7:0]         underrun0, underrun1;

  hdmi_audio_sched u_dut (
    .clk_pixel(clk), .resetn(resetn),
    .src0_valid(src0_valid), .src0_ready(src0_ready), .src0_l(src0_l), .src0_r(src0_r),
    .src1_valid(src1_valid), .src1_ready(src1_ready), .src1_l(src1_l), .src1_r(src1_r),
    .cfg_en(cfg_en), .cfg_shift0(cfg_shift0), .cfg_shift1(cfg_shift1), .clr_stats(clr_stats),
    .clk_audio(clk_audio), .sample_tick(sample_tick), .audio0(audio0), .audio1(audio1),
    .underrun0(underrun0), .underrun1(underrun1)
  );

  // Fast instance: 96 increments against 960 gives a toggle every 10 cycles
  logic               f_resetn = 1'b0;
  logic               f_src0_valid = 1'b0, f_src1_valid = 1'b0;
  logic               f_src0_ready, f_src1_ready;
  logic signed [15:0] f_src0_l = '0, f_src0_r = '0, f_src1_l = '0, f_src1_r = '0;
  logic [1:0]         f_cfg_en = 2'b01;
  logic               f_clr_stats = 1'b0;
  logic               f_clk_audio, f_sample_tick;
  logic signed [15:0] f_audio0, f_audio1;
  logic [7:0]         f_underrun0, f_underrun1;

  hdmi_audio_sched #(.CLK_HZ(960), .SAMPLE_HZ(48), .ACC_W(27)) u_fast (
    .clk_pixel(clk), .resetn(f_resetn),
    .src0_valid(f_src0_valid), .src0_ready(f_src0_ready), .src0_l(f_src0_l), .src0_r(f_src0_r),
    .src1_valid(f_src1_valid), .src1_ready(f_src1_ready), .src1_l(f_src1_l), .src1_r(f_src1_r),
    .cfg_en(f_cfg_en), .cfg_shift0(2'd0), .cfg_shift1(2'd0), .clr_stats(f_clr_stats),
    .clk_audio(f_clk_audio), .sample_tick(f_sample_tick), .audio0(f_audio0), .audio1(f_audio1),
    .underrun0(f_underrun0), .underrun1(f_underrun1)
  );

  int accepts0 = 0;
  always @(posedge clk) if (src0_valid && src0_ready) accepts0 <= accepts0 + 1;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Returns 1 ns after the edge on which clk_audio fell.
  task automatic wait_fall();
    logic prev;
    for (int i = 0; i < 2000; i++) begin
      prev = clk_audio;
      step(1);
      if (prev === 1'b1 && clk_audio === 1'b0) return;
    end
    $display("FAIL wait_fall: clk_audio falling edge not seen within 2000 cycles");
    $fatal(1, "clk_audio stalled");
  endtask

  task automatic do_mix(input logic [1:0] en, input logic [1:0] sh0, input logic [1:0] sh1,
                        input logic [15:0] l0, input logic [15:0] r0,
                        input logic [15:0] l1, input logic [15:0] r1);
    cfg_en = en; cfg_shift0 = sh0; cfg_shift1 = sh1;
    src0_l = l0; src0_r = r0; src1_l = l1; src1_r = r1;
    src0_valid = 1'b1; src1_valid = 1'b1;
    step(1);
    src0_valid = 1'b0; src1_valid = 1'b0;
    wait_fall();
    step(3);
  endtask

  task automatic test_underrun_saturate();
    step(2);
    f_resetn = 1'b1;
    f_src0_l = 16'h1234; f_src0_r = 16'hFEDC; f_src0_valid = 1'b1;
    step(1);
    f_src0_valid = 1'b0;
    step(23);
    total++; if (f_audio0 !== 16'h1234) $display("FAIL fast_first_l: got %h want 1234", f_audio0); else passed++;
    total++; if (f_audio1 !== 16'hFEDC) $display("FAIL fast_first_r: got %h want fedc", f_audio1); else passed++;
    total++; if (f_underrun0 !== 8'd0) $display("FAIL fast_urun_first: got %0d want 0", f_underrun0); else passed++;
    step(77);
    total++; if (f_underrun0 !== 8'd4) $display("FAIL fast_urun_4: got %0d want 4", f_underrun0); else passed++;
    step(5900);
    total++; if (f_underrun0 !== 8'd255) $display("FAIL fast_urun_sat: got %0d want 255", f_underrun0); else passed++;
    step(40);
    total++; if (f_underrun0 !== 8'd255) $display("FAIL fast_urun_stay: got %0d want 255", f_underrun0); else passed++;
    total++; if (f_audio0 !== 16'h1234) $display("FAIL fast_hold_l: got %h want 1234", f_audio0); else passed++;
    total++; if (f_underrun1 !== 8'd0) $display("FAIL fast_urun1: got %0d want 0", f_underrun1); else passed++;
  endtask

  task automatic test_reset();
    step(1);
    total++; if (clk_audio !== 1'b0) $display("FAIL rst_clk_audio: got %b want 0", clk_audio); else passed++;
    total++; if (sample_tick !== 1'b0) $display("FAIL rst_tick: got %b want 0", sample_tick); else passed++;
    total++; if (audio0 !== 16'h0000 || audio1 !== 16'h0000) $display("FAIL rst_audio: got %h/%h want 0000/0000", audio0, audio1); else passed++;
    total++; if (src0_ready !== 1'b0 || src1_ready !== 1'b0) $display("FAIL rst_ready: got %b%b want 00", src1_ready, src0_ready); else passed++;
    total++; if (underrun0 !== 8'd0 || underrun1 !== 8'd0) $display("FAIL rst_underrun: got %0d/%0d want 0/0", underrun0, underrun1); else passed++;
    resetn = 1'b1;
    step(1);
    total++; if (src0_ready !== 1'b1 || src1_ready !== 1'b1) $display("FAIL rel_ready: got %b%b want 11", src1_ready, src0_ready); else passed++;
  endtask

  task automatic test_phase();
    step(415);
    total++; if (clk_audio !== 1'b0) $display("FAIL ph_416: got %b want 0", clk_audio); else passed++;
    step(1);
    total++; if (clk_audio !== 1'b1) $display("FAIL ph_417: got %b want 1", clk_audio); else passed++;
    total++; if (sample_tick !== 1'b1) $display("FAIL tick_417: got %b want 1", sample_tick); else passed++;
    step(1);
    total++; if (sample_tick !== 1'b0) $display("FAIL tick_418: got %b want 0", sample_tick); else passed++;
    step(415);
    total++; if (clk_audio !== 1'b1) $display("FAIL ph_833: got %b want 1", clk_audio); else passed++;
    step(1);
    total++; if (clk_audio !== 1'b0 || sample_tick !== 1'b0) $display("FAIL ph_834: got clk=%b tick=%b want 0/0", clk_audio, sample_tick); else passed++;
    step(415);
    total++; if (clk_audio !== 1'b0) $display("FAIL ph_1249: got %b want 0", clk_audio); else passed++;
    step(1);
    total++; if (clk_audio !== 1'b1 || sample_tick !== 1'b1) $display("FAIL ph_1250: got clk=%b tick=%b want 1/1", clk_audio, sample_tick); else passed++;
    step(416);
    total++; if (clk_audio !== 1'b1) $display("FAIL ph_1666: got %b want 1", clk_audio); else passed++;
    step(1);
    total++; if (clk_audio !== 1'b0) $display("FAIL ph_1667: got %b want 0", clk_audio); else passed++;
  endtask

  task automatic test_saturation();
    step(5);
    cfg_en = 2'b11; cfg_shift0 = 2'd0; cfg_shift1 = 2'd0;
    src0_l = 16'h6000; src0_r = 16'h0000; src1_l = 16'h3000; src1_r = 16'h0000;
    src0_valid = 1'b1; src1_valid = 1'b1;
    step(1);
    src0_valid = 1'b0; src1_valid = 1'b0;
    total++; if (src0_ready !== 1'b0) $display("FAIL held_not_ready: got %b want 0", src0_ready); else passed++;
    wait_fall();
    step(1);
    total++; if (src0_ready !== 1'b1) $display("FAIL snap_frees: got %b want 1", src0_ready); else passed++;
    step(2);
    total++; if (audio0 !== 16'h7FFF) $display("FAIL sat_pos: got %h want 7fff", audio0); else passed++;
    total++; if (audio1 !== 16'h0000) $display("FAIL sat_pos_r: got %h want 0000", audio1); else passed++;
    do_mix(2'b11, 2'd0, 2'd0, 16'h1000, 16'h8000, 16'h0234, 16'hF000);
    total++; if (audio1 !== 16'h8000) $display("FAIL sat_neg: got %h want 8000", audio1); else passed++;
    total++; if (audio0 !== 16'h1234) $display("FAIL plain_sum: got %h want 1234", audio0); else passed++;
  endtask

  task automatic test_attenuation();
    do_mix(2'b01, 2'd2, 2'd0, 16'h4000, 16'hFFF0, 16'h7000, 16'h7000);
    total++; if (audio0 !== 16'h1000) $display("FAIL attn2_l: got %h want 1000", audio0); else passed++;
    total++; if (audio1 !== 16'hFFFC) $display("FAIL attn2_r: got %h want fffc", audio1); else passed++;
    total++; if (src1_ready !== 1'b1) $display("FAIL disabled_drain: got %b want 1", src1_ready); else passed++;
    do_mix(2'b11, 2'd3, 2'd1, 16'h8001, 16'h7FFF, 16'h0010, 16'h7FFF);
    total++; if (audio0 !== 16'hF008) $display("FAIL attn31_l: got %h want f008", audio0); else passed++;
    total++; if (audio1 !== 16'h4FFE) $display("FAIL attn31_r: got %h want 4ffe", audio1); else passed++;
    cfg_shift0 = 2'd0;
    step(20);
    total++; if (audio0 !== 16'hF008) $display("FAIL audio_held: got %h want f008", audio0); else passed++;
  endtask

  task automatic test_underrun();
    cfg_en = 2'b01; cfg_shift0 = 2'd0; cfg_shift1 = 2'd0;
    clr_stats = 1'b1;
    step(1);
    clr_stats = 1'b0;
    total++; if (underrun0 !== 8'd0 || underrun1 !== 8'd0) $display("FAIL clr_stats: got %0d/%0d want 0/0", underrun0, underrun1); else passed++;
    src0_l = 16'h2345; src0_r = 16'h0100; src0_valid = 1'b1;
    step(1);
    src0_valid = 1'b0;
    wait_fall();
    step(3);
    total++; if (audio0 !== 16'h2345 || audio1 !== 16'h0100) $display("FAIL ur_fed: got %h/%h want 2345/0100", audio0, audio1); else passed++;
    total++; if (underrun0 !== 8'd0) $display("FAIL ur_fed_cnt: got %0d want 0", underrun0); else passed++;
    wait_fall();
    step(3);
    total++; if (audio0 !== 16'h2345) $display("FAIL ur_repeat: got %h want 2345", audio0); else passed++;
    total++; if (underrun0 !== 8'd1) $display("FAIL ur_cnt1: got %0d want 1", underrun0); else passed++;
    wait_fall();
    step(1);
    total++; if (underrun0 !== 8'd2) $display("FAIL ur_cnt2: got %0d want 2", underrun0); else passed++;
    step(2);
  endtask

  task automatic test_back_to_back();
    int a0;
    src0_l = 16'h0111; src0_r = 16'h0222; src0_valid = 1'b1;
    step(1);
    total++; if (src0_ready !== 1'b0) $display("FAIL b2b_first: got %b want 0", src0_ready); else passed++;
    wait_fall();
    total++; if (src0_ready !== 1'b0) $display("FAIL b2b_wait: got %b want 0", src0_ready); else passed++;
    step(1);
    total++; if (src0_ready !== 1'b1) $display("FAIL b2b_after_snap: got %b want 1", src0_ready); else passed++;
    a0 = accepts0;
    step(1);
    total++; if (src0_ready !== 1'b0) $display("FAIL b2b_reload: got %b want 0", src0_ready); else passed++;
    wait_fall();
    step(1);
    total++; if (accepts0 - a0 !== 1) $display("FAIL b2b_accepts: got %0d want 1", accepts0 - a0); else passed++;
    step(2);
    total++; if (audio0 !== 16'h0111 || audio1 !== 16'h0222) $display("FAIL b2b_data: got %h/%h want 0111/0222", audio0, audio1); else passed++;
    src0_valid = 1'b0;
  endtask

  task automatic test_reset_mid_mix();
    wait_fall();
    step(1);
    resetn = 1'b0;
    step(1);
    total++; if (audio0 !== 16'h0000 || audio1 !== 16'h0000) $display("FAIL mid_rst_audio: got %h/%h want 0000/0000", audio0, audio1); else passed++;
    total++; if (clk_audio !== 1'b0 || underrun0 !== 8'd0) $display("FAIL mid_rst_state: got clk=%b ur=%0d want 0/0", clk_audio, underrun0); else passed++;
    total++; if (src0_ready !== 1'b0) $display("FAIL mid_rst_ready: got %b want 0", src0_ready); else passed++;
    resetn = 1'b1;
    step(3);
    total++; if (audio0 !== 16'h0000) $display("FAIL mid_rst_discard: got %h want 0000", audio0); else passed++;
    step(413);
    total++; if (clk_audio !== 1'b0) $display("FAIL re_ph_416: got %b want 0", clk_audio); else passed++;
    step(1);
    total++; if (clk_audio !== 1'b1) $display("FAIL re_ph_417: got %b want 1", clk_audio); else passed++;
    wait_fall();
    step(1);
    total++; if (underrun0 !== 8'd1) $display("FAIL never_fed_cnt: got %0d want 1", underrun0); else passed++;
    step(2);
    total++; if (audio0 !== 16'h0000) $display("FAIL never_fed_silence: got %h want 0000", audio0); else passed++;
    wait_fall();
    clr_stats = 1'b1;
    step(1);
    clr_stats = 1'b0;
    total++; if (underrun0 !== 8'd0) $display("FAIL clr_beats_snap: got %0d want 0", underrun0); else passed++;
    wait_fall();
    step(1);
    total++; if (underrun0 !== 8'd1 || underrun1 !== 8'd0) $display("FAIL clr_restart: got %0d/%0d want 1/0", underrun0, underrun1); else passed++;
  endtask

  initial begin
    test_underrun_saturate();
    test_reset();
    test_phase();
    test_saturation();
    test_attenuation();
    test_underrun();
    test_back_to_back();
    cfg_en = 2'b01;
    test_reset_mid_mix();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
